// File: rtl/led_seq_pkg.sv
// Shared encodings and helpers for the LED sequencer.
package led_seq_pkg;

    localparam logic [1:0] MODE_ROT_UP = 2'd0;
    localparam logic [1:0] MODE_ROT_DN = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    function automatic int step_cycles(input int clk_hz, input int step_ms);
        return clk_hz / 1000 * step_ms;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step timebase: tick is high combinationally in the last enabled cycle of each period.
// Counter freezes while enable is low and resumes from the held count.
module step_prescaler #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate up/down, bounce, blink-all, advancing one step per prescaler tick.
// led/pos update on the tick edge; step_pulse is high the cycle after.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_COUNT = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int STEP_MS   = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    output logic [LED_COUNT-1:0]         led,
    output logic [$clog2(LED_COUNT)-1:0] pos,
    output logic                         step_pulse
);

    localparam int PW          = $clog2(LED_COUNT);
    localparam int STEP_CYCLES = step_cycles(CLK_HZ, STEP_MS);
    localparam logic [PW-1:0] LAST = PW'(LED_COUNT - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [LED_COUNT-1:0] LED_ONE = LED_COUNT'(1);

    logic tick;

    logic [LED_COUNT-1:0] led_q, led_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [1:0]           mode_q, mode_d;
    dir_t                 dir_q, dir_d, dir_v;
    logic                 started_q, started_d;
    logic                 blink_q, blink_d;
    logic                 pulse_q;

    step_prescaler #(
        .CYCLES (STEP_CYCLES)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        led_d     = led_q;
        pos_d     = pos_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        started_d = started_q;
        blink_d   = blink_q;
        // Direction re-derived from pos when bounce is freshly entered.
        dir_v     = (mode_q != MODE_BOUNCE) ? ((pos_q == LAST) ? DIR_DN : DIR_UP) : dir_q;
        if (tick) begin
            mode_d    = mode;
            started_d = 1'b1;
            if (!started_q) begin
                pos_d = (mode == MODE_ROT_DN) ? LAST : '0;
                if (mode == MODE_BLINK) begin
                    led_d   = '1;
                    blink_d = 1'b1;
                end else begin
                    led_d = LED_ONE << pos_d;
                end
            end else begin
                case (mode)
                    MODE_ROT_UP: begin
                        pos_d = (pos_q == LAST) ? '0 : pos_q + ONE;
                        led_d = LED_ONE << pos_d;
                    end
                    MODE_ROT_DN: begin
                        pos_d = (pos_q == '0) ? LAST : pos_q - ONE;
                        led_d = LED_ONE << pos_d;
                    end
                    MODE_BOUNCE: begin
                        if (dir_v == DIR_UP) begin
                            if (pos_q == LAST) begin
                                dir_d = DIR_DN;
                                pos_d = LAST - ONE;
                            end else begin
                                dir_d = DIR_UP;
                                pos_d = pos_q + ONE;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = ONE;
                            end else begin
                                dir_d = DIR_DN;
                                pos_d = pos_q - ONE;
                            end
                        end
                        led_d = LED_ONE << pos_d;
                    end
                    default: begin
                        blink_d = ~blink_q;
                        led_d   = blink_d ? '1 : '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            pos_q     <= '0;
            mode_q    <= MODE_ROT_UP;
            dir_q     <= DIR_UP;
            started_q <= 1'b0;
            blink_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            led_q     <= led_d;
            pos_q     <= pos_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            started_q <= started_d;
            blink_q   <= blink_d;
            pulse_q   <= tick;
        end
    end

    assign led        = led_q;
    assign pos        = pos_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer with a 4-cycle step; expected LED words are queued per scenario.
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] led;
    logic [1:0] pos;
    logic       step_pulse;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    led_sequencer #(
        .LED_COUNT (4),
        .CLK_HZ    (1000),
        .STEP_MS   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .led        (led),
        .pos        (pos),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    // Scoreboard: every step strobe must match the next queued LED word.
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL step_unexpected led=%b required=no step", led);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (led !== e) begin
                    bad++;
                    $display("FAIL step_led led=%b required=%b", led, e);
                end
            end
        end
    end

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;
        mode   = m;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        total++;
        if (led !== 4'b0000 || pos !== 2'd0 || step_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_values led=%b pos=%0d pulse=%b required=0000/0/0", led, pos, step_pulse);
        end
    endtask

    task automatic test_rotate_up;
        do_reset(2'd0);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            total++;
            if (step_pulse !== (k % 4 == 0)) begin
                bad++;
                $display("FAIL rot_up_pulse cycle=%0d pulse=%b required=%b", k, step_pulse, (k % 4 == 0));
            end
            if (k < 4) begin
                total++;
                if (led !== 4'b0000) begin
                    bad++;
                    $display("FAIL rot_up_idle cycle=%0d led=%b required=0000", k, led);
                end
            end
        end
    endtask

    task automatic test_bounce;
        do_reset(2'd2);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            total++;
            if (step_pulse !== (k % 4 == 0)) begin
                bad++;
                $display("FAIL bounce_pulse cycle=%0d pulse=%b required=%b", k, step_pulse, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_rotate_down;
        do_reset(2'd1);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b1000);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) begin
                total++;
                if (pos !== 2'd3) begin
                    bad++;
                    $display("FAIL rot_dn_pos pos=%0d required=3", pos);
                end
            end
        end
    endtask

    task automatic test_blink_then_rotate;
        do_reset(2'd3);
        exp_q.push_back(4'b1111); exp_q.push_back(4'b0000); exp_q.push_back(4'b1111);
        repeat (12) @(negedge clk);
        total++;
        if (pos !== 2'd0) begin
            bad++;
            $display("FAIL blink_pos pos=%0d required=0", pos);
        end
        mode = 2'd0;
        exp_q.push_back(4'b0010);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                total++;
                if (led !== 4'b1111) begin
                    bad++;
                    $display("FAIL blink_hold cycle=%0d led=%b required=1111", k, led);
                end
            end
        end
    endtask

    task automatic test_pause;
        do_reset(2'd0);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        repeat (6) @(negedge clk);
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (step_pulse !== 1'b0 || led !== 4'b0001) begin
                bad++;
                $display("FAIL pause_hold cycle=%0d led=%b pulse=%b required=0001/0", k, led, step_pulse);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            total++;
            if (step_pulse !== (k == 2)) begin
                bad++;
                $display("FAIL resume_pulse cycle=%0d pulse=%b required=%b", k, step_pulse, (k == 2));
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(2'd0);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (led !== 4'b0000 || step_pulse !== 1'b0) begin
            bad++;
            $display("FAIL async_reset led=%b pulse=%b required=0000/0", led, step_pulse);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (step_pulse !== (k % 4 == 0)) begin
                bad++;
                $display("FAIL post_reset_pulse cycle=%0d pulse=%b required=%b", k, step_pulse, (k % 4 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotate_up();
        test_bounce();
        test_rotate_down();
        test_blink_then_rotate();
        test_pause();
        test_reset_mid();
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL steps_missing pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
